// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler
//
// Drives the LFSR enable, reads the stepped LFSR state and reduces it to a
// uniformly distributed value in [0, limit) using mask-and-reject sampling.
// The result is offered on a valid/ready handshake and held until taken.
//
// State table
//   state | meaning
//   IDLE  | waiting for req_i; limit/mask latched on accept
//   STEP  | one-cycle LFSR enable pulse
//   CHECK | evaluate post-step LFSR state: lock-up, accept or reject
//   HOLD  | sample presented on data_o, waiting for ready_i
//
// Ports
//   clk        : rising-edge clock
//   reset_n_i  : asynchronous active-low reset
//   lfsr_q_i   : current LFSR state
//   lfsr_en_o  : LFSR advance enable (high only in STEP)
//   req_i      : request one sample (sampled in IDLE only)
//   limit_i    : exclusive upper bound, 0 means 256
//   busy_o     : high whenever not IDLE
//   valid_o    : data_o holds an accepted sample
//   ready_i    : consumer takes data_o when valid_o & ready_i
//   data_o     : sample, < limit unless limit is 0
//   discards_o : rejected draws of the current/last transaction, saturating
//   stuck_o    : sticky all-zero LFSR state flag
module lfsr_range_sampler (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [7:0] lfsr_q_i,
    output logic       lfsr_en_o,
    input  logic       req_i,
    input  logic [7:0] limit_i,
    output logic       busy_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic [7:0] discards_o,
    output logic       stuck_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] limit_q, limit_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] data_q, data_d;
    logic [7:0] discards_q, discards_d;
    logic       valid_q, valid_d;
    logic       stuck_q, stuck_d;

    // Smearing limit-1 to the right fills every bit below its MSB. This
    // naturally gives 0xFF for limit 0 (wraps to 0xFF) and 0x00 for limit 1.
    logic [7:0] limit_m1;
    logic [7:0] smear_1;
    logic [7:0] smear_2;
    logic [7:0] mask_calc;
    logic [7:0] cand;
    logic       cand_ok;

    assign limit_m1  = limit_i - 8'd1;
    assign smear_1   = limit_m1 | (limit_m1 >> 1);
    assign smear_2   = smear_1 | (smear_1 >> 2);
    assign mask_calc = smear_2 | (smear_2 >> 4);

    assign cand    = lfsr_q_i & mask_q;
    assign cand_ok = (limit_q == 8'd0) || (cand < limit_q);

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        mask_d     = mask_q;
        data_d     = data_q;
        discards_d = discards_q;
        valid_d    = valid_q;
        stuck_d    = stuck_q;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    limit_d    = limit_i;
                    mask_d     = mask_calc;
                    discards_d = 8'd0;
                    state_d    = STEP;
                end
            end
            STEP: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (lfsr_q_i == 8'd0) begin
                    stuck_d = 1'b1;
                    state_d = IDLE;
                end else if (cand_ok) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    if (discards_q != 8'hFF) begin
                        discards_d = discards_q + 8'd1;
                    end
                    state_d = STEP;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            limit_q    <= 8'd0;
            mask_q     <= 8'd0;
            data_q     <= 8'd0;
            discards_q <= 8'd0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            discards_q <= discards_d;
            valid_q    <= valid_d;
            stuck_q    <= stuck_d;
        end
    end

    // Decoded from state so the async reset removes the enable immediately.
    assign lfsr_en_o  = (state_q == STEP);
    assign busy_o     = (state_q != IDLE);
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign discards_o = discards_q;
    assign stuck_o    = stuck_q;

endmodule
